// File: rtl/window_compare_counter_if.sv
// Sample-in / record-out bundle for window_compare_counter.
// master drives samples and consumes records; slave is the counter itself.
interface window_compare_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  logic [WIDTH-1:0] thresh;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_gr;
  logic [CNT_W-1:0] cnt_lw;
  logic [CNT_W-1:0] cnt_eq;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;

  modport master (
    output thresh, in_valid, in_data, out_ready,
    input  in_ready, out_valid, cnt_gr, cnt_lw, cnt_eq, min_val, max_val
  );

  modport slave (
    input  thresh, in_valid, in_data, out_ready,
    output in_ready, out_valid, cnt_gr, cnt_lw, cnt_eq, min_val, max_val
  );
endinterface

// File: rtl/window_compare_counter.sv
// Counts >, <, == threshold outcomes and min/max over WINDOW samples; record valid the cycle after the last sample.
// Input stalls (in_ready=0) while a record is held; record held until out_ready.
module window_compare_counter #(
  parameter  int WIDTH  = 4,
  parameter  int WINDOW = 8,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  window_compare_counter_if.slave  bus
);
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] gr_acc, lw_acc, eq_acc;
  logic [WIDTH-1:0] min_acc, max_acc;
  logic             out_vld;
  logic [CNT_W-1:0] gr_q, lw_q, eq_q;
  logic [WIDTH-1:0] min_q, max_q;

  logic             equal, lower, greater;
  logic             take, last;
  logic [CNT_W-1:0] gr_nxt, lw_nxt, eq_nxt;
  logic [WIDTH-1:0] min_nxt, max_nxt;

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .a       (bus.in_data),
    .b       (bus.thresh),
    .equal   (equal),
    .lower   (lower),
    .greater (greater)
  );

  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = out_vld;
  assign bus.cnt_gr    = gr_q;
  assign bus.cnt_lw    = lw_q;
  assign bus.cnt_eq    = eq_q;
  assign bus.min_val   = min_q;
  assign bus.max_val   = max_q;

  assign take = bus.in_valid && (state == COLLECT);
  assign last = (idx == CNT_W'(WINDOW - 1));

  // Accumulator values including the current sample; the first sample seeds min/max.
  always_comb begin
    gr_nxt  = gr_acc + CNT_W'(greater);
    lw_nxt  = lw_acc + CNT_W'(lower);
    eq_nxt  = eq_acc + CNT_W'(equal);
    min_nxt = min_acc;
    max_nxt = max_acc;
    if (idx == '0 || bus.in_data < min_acc) min_nxt = bus.in_data;
    if (idx == '0 || bus.in_data > max_acc) max_nxt = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      idx     <= '0;
      gr_acc  <= '0;
      lw_acc  <= '0;
      eq_acc  <= '0;
      min_acc <= '0;
      max_acc <= '0;
      out_vld <= 1'b0;
      gr_q    <= '0;
      lw_q    <= '0;
      eq_q    <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (take) begin
            if (last) begin
              gr_q    <= gr_nxt;
              lw_q    <= lw_nxt;
              eq_q    <= eq_nxt;
              min_q   <= min_nxt;
              max_q   <= max_nxt;
              out_vld <= 1'b1;
              idx     <= '0;
              gr_acc  <= '0;
              lw_acc  <= '0;
              eq_acc  <= '0;
              min_acc <= '0;
              max_acc <= '0;
              state   <= HOLD;
            end else begin
              idx     <= idx + 1'b1;
              gr_acc  <= gr_nxt;
              lw_acc  <= lw_nxt;
              eq_acc  <= eq_nxt;
              min_acc <= min_nxt;
              max_acc <= max_nxt;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             lower,
  output logic             greater
);
  assign equal   = (a == b);
  assign lower   = (a < b);
  assign greater = (a > b);
endmodule
